// File: rtl/cache_types_pkg.sv
// Shared types for the instruction cache: address split, frame layout, fill FSM states.
package cache_types_pkg;

    localparam int unsigned ICACHE_SETS  = 16;
    localparam int unsigned ICACHE_CNT_W = 32;
    localparam int unsigned ICACHE_IDX_W = $clog2(ICACHE_SETS);
    localparam int unsigned ICACHE_TAG_W = 32 - ICACHE_IDX_W - 2;

    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icachef_t;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        logic [31:0]             data;
    } icache_frame_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_direct.sv
// Direct-mapped, single-word-block, read-only instruction cache with a blocking fill FSM
// and saturating hit/miss counters.
module icache_direct
    import cache_types_pkg::*;
#(
    parameter int unsigned SETS  = ICACHE_SETS,
    parameter int unsigned CNT_W = ICACHE_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             imemREN,
    input  logic [31:0]      imemaddr,
    output logic             ihit,
    output logic [31:0]      imemload,
    input  logic             flush,
    output logic             iREN,
    output logic [31:0]      iaddr,
    input  logic             iwait,
    input  logic [31:0]      iload,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = 32 - IDX_W - 2;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
        logic [1:0]       bytoff;
    } addr_t;

    icache_state_t    state, state_next;
    addr_t            req;
    addr_t            miss_addr;
    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tags  [SETS];
    logic [31:0]      datas [SETS];
    logic             flush_seen;
    logic             hit;
    logic             miss_start;
    logic             fill_done;
    logic             unused_bytoff;

    assign req           = imemaddr;
    assign unused_bytoff = ^req.bytoff;

    // State register; reset aborts any fill in flight
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, hit path and memory request
    always_comb begin
        state_next = state;
        hit        = 1'b0;
        miss_start = 1'b0;
        fill_done  = 1'b0;
        ihit       = 1'b0;
        imemload   = '0;
        iREN       = 1'b0;
        iaddr      = '0;
        case (state)
            IDLE: begin
                hit = imemREN & valid[req.idx] & (tags[req.idx] == req.tag);
                if (hit) begin
                    ihit     = 1'b1;
                    imemload = datas[req.idx];
                end else if (imemREN) begin
                    miss_start = 1'b1;
                    state_next = FILL;
                end
            end
            FILL: begin
                iREN  = 1'b1;
                iaddr = miss_addr;
                if (!iwait) begin
                    fill_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Miss address is captured once; the fetch port is ignored until the fill retires
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            miss_addr <= '0;
        end else if (miss_start) begin
            miss_addr <= {req.tag, req.idx, 2'b00};
        end
    end

    // A flush seen at any point of the fill keeps the filled frame invalid
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            flush_seen <= 1'b0;
        end else if (fill_done) begin
            flush_seen <= 1'b0;
        end else if ((state == FILL) && flush) begin
            flush_seen <= 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (fill_done) begin
            valid[miss_addr.idx] <= ~flush_seen;
        end
    end

    // Tag/data storage carries no reset; valid gates every use
    always_ff @(posedge CLK) begin
        if (fill_done) begin
            tags[miss_addr.idx]  <= miss_addr.tag;
            datas[miss_addr.idx] <= iload;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit && (hit_count != {CNT_W{1'b1}})) begin
                hit_count <= hit_count + CNT_W'(1);
            end
            if (miss_start && (miss_count != {CNT_W{1'b1}})) begin
                miss_count <= miss_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct: fills, conflicts, mid-fill changes, flush, async reset,
// and counter saturation on a narrow-counter instance.
module tb_icache_direct;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        flush;
    logic        iwait;
    logic [31:0] iload;

    logic        ihit, iREN;
    logic [31:0] imemload, iaddr, hit_count, miss_count;
    logic        ihit4, iREN4;
    logic [31:0] imemload4, iaddr4;
    logic [3:0]  hit4, miss4;

    int lat;
    int wcnt;
    int n_checks = 0;
    int n_fail   = 0;
    int exp_hit  = 0;
    int exp_miss = 0;

    icache_direct #(.SETS(16), .CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .flush(flush), .iREN(iREN), .iaddr(iaddr),
        .iwait(iwait), .iload(iload), .hit_count(hit_count), .miss_count(miss_count)
    );

    icache_direct #(.SETS(16), .CNT_W(4)) dut4 (
        .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit4), .imemload(imemload4), .flush(flush), .iREN(iREN4), .iaddr(iaddr4),
        .iwait(iwait), .iload(iload), .hit_count(hit4), .miss_count(miss4)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0040: return 32'h2002_0005;
            32'h0000_0080: return 32'h8C01_0080;
            default:       return {16'hBEEF, a[15:0]};
        endcase
    endfunction

    // Memory: data valid after lat busy cycles of an active request
    always @(posedge CLK or posedge RST) begin
        if (RST)                 wcnt <= 0;
        else if (iREN && !iwait) wcnt <= 0;
        else if (iREN)           wcnt <= wcnt + 1;
    end
    assign iwait = iREN && (wcnt < lat);
    assign iload = mem_word(iaddr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_hc"}, hit_count, 32'(exp_hit));
        check({tag, "_mc"}, miss_count, 32'(exp_miss));
    endtask

    // One fetch; on a miss also checks the request window and the replay latency
    task automatic fetch(input string tag, input logic [31:0] a, input bit want_miss);
        int cyc;
        int ren;
        @(negedge CLK);
        imemREN  = 1'b1;
        imemaddr = a;
        #1;
        if (want_miss) begin
            check({tag, "_nohit"}, 32'(ihit), 32'd0);
            exp_miss++;
            @(negedge CLK); #1;
            cyc = 1;
            check({tag, "_iren"}, 32'(iREN), 32'd1);
            check({tag, "_iaddr"}, iaddr, {a[31:2], 2'b00});
            ren = (iREN === 1'b1) ? 1 : 0;
            while (ihit !== 1'b1 && cyc < 60) begin
                @(negedge CLK); #1;
                cyc++;
                if (iREN === 1'b1) ren++;
            end
            check({tag, "_lat"}, 32'(cyc), 32'(lat + 2));
            check({tag, "_rencyc"}, 32'(ren), 32'(lat + 1));
        end
        check({tag, "_hit"}, 32'(ihit), 32'd1);
        check({tag, "_data"}, imemload, mem_word({a[31:2], 2'b00}));
        exp_hit++;
        @(negedge CLK);
        imemREN = 1'b0;
        #1;
        check_counts(tag);
    endtask

    task automatic wait_idle(input string tag);
        int cyc;
        cyc = 0;
        while (iREN !== 1'b0 && cyc < 60) begin
            @(negedge CLK); #1;
            cyc++;
        end
        check({tag, "_idle"}, 32'(iREN), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RST      = 1'b1;
        imemREN  = 1'b0;
        imemaddr = '0;
        flush    = 1'b0;
        lat      = 2;
        #1;
        check("rst_ihit", 32'(ihit), 32'd0);
        check("rst_imemload", imemload, 32'd0);
        check("rst_iren", 32'(iREN), 32'd0);
        check("rst_iaddr", iaddr, 32'd0);
        check_counts("rst");
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        // Cold miss, 2 wait cycles, replay hit
        fetch("t1", 32'h0000_0040, 1'b1);

        // Conflict on idx 0: 0x80 evicts 0x40
        lat = 1;
        fetch("t2_80", 32'h0000_0080, 1'b1);
        fetch("t2_40", 32'h0000_0040, 1'b1);
        fetch("t2_40h", 32'h0000_0040, 1'b0);

        // Address change mid-fill: latched line completes
        lat = 3;
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = 32'h0000_0044;
        #1 check("t3_nohit", 32'(ihit), 32'd0);
        exp_miss++;
        @(negedge CLK);
        imemaddr = 32'h0000_0048;
        #1 check("t3_iaddr_a", iaddr, 32'h0000_0044);
        @(negedge CLK);
        imemREN = 1'b0; imemaddr = 32'h0;
        #1 check("t3_iaddr_b", iaddr, 32'h0000_0044);
        wait_idle("t3");
        fetch("t3_44", 32'h0000_0044, 1'b0);
        fetch("t3_48", 32'h0000_0048, 1'b1);

        // Idle with no request: counters hold
        repeat (3) @(negedge CLK);
        #1 check_counts("idle_hold");

        // Flush during fill leaves the frame invalid
        lat = 2;
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = 32'h0000_0010;
        #1 check("t4_nohit", 32'(ihit), 32'd0);
        exp_miss++;
        @(negedge CLK);
        imemREN = 1'b0; flush = 1'b1;
        #1 check("t4_iren", 32'(iREN), 32'd1);
        @(negedge CLK);
        flush = 1'b0;
        wait_idle("t4");
        check_counts("t4_fill");
        fetch("t4_refetch", 32'h0000_0010, 1'b1);

        // Flush coincident with a hit: hit served, then frame gone
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = 32'h0000_0010; flush = 1'b1;
        #1;
        check("t4_flushhit", 32'(ihit), 32'd1);
        check("t4_flushdata", imemload, mem_word(32'h0000_0010));
        exp_hit++;
        @(negedge CLK);
        imemREN = 1'b0; flush = 1'b0;
        fetch("t4_after", 32'h0000_0010, 1'b1);
        fetch("t4_44", 32'h0000_0044, 1'b1);
        fetch("t4_44h", 32'h0000_0044, 1'b0);

        // Async reset mid-fill
        lat = 5;
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = 32'h0000_0020;
        @(negedge CLK);
        imemREN = 1'b0;
        #1 check("t5_iren_pre", 32'(iREN), 32'd1);
        #2 RST = 1'b1;
        #1;
        check("t5_iren_async", 32'(iREN), 32'd0);
        check("t5_hc", hit_count, 32'd0);
        check("t5_mc", miss_count, 32'd0);
        check("t5_hc4", 32'(hit4), 32'd0);
        exp_hit  = 0;
        exp_miss = 0;
        @(negedge CLK);
        #2 RST = 1'b0;
        lat = 1;
        fetch("t5_44", 32'h0000_0044, 1'b1);
        fetch("t5_20", 32'h0000_0020, 1'b1);

        // Saturation on the 4-bit counter instance
        fetch("t6_48", 32'h0000_0048, 1'b1);
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = 32'h0000_0048;
        repeat (19) @(negedge CLK);
        imemREN = 1'b0;
        exp_hit += 19;
        #1;
        check_counts("t6");
        check("t6_hc4_sat", 32'(hit4), 32'd15);
        check("t6_mc4", 32'(miss4), 32'd3);
        fetch("t6_more", 32'h0000_0048, 1'b0);
        check("t6_hc4_hold", 32'(hit4), 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
